// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the single-precision FloPoCo divider adapter.
// Defines the 34-bit FloPoCo word layout and its exception-code encoding.
package fpdiv_pkg;

    localparam int FP_SP_W = 34;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef struct packed {
        logic [1:0]  exc;
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } flopoco_sp_t;

endpackage

// File: rtl/fpdiv_sp_stream_adapter_if.sv
// Handshake and divider-side bundle of the divider stream adapter.
// Ports: operand stream (in_*), result stream (out_*), divider hookup (div_*).
interface fpdiv_sp_stream_adapter_if;
    import fpdiv_pkg::*;

    logic        in_valid;
    logic        in_ready;
    flopoco_sp_t in_x;
    flopoco_sp_t in_y;
    logic        div_ce;
    flopoco_sp_t div_x;
    flopoco_sp_t div_y;
    flopoco_sp_t div_r;
    logic        out_valid;
    logic        out_ready;
    flopoco_sp_t out_r;

    // Environment side: operand producer, result consumer and divider.
    modport master (
        output in_valid, in_x, in_y, out_ready, div_r,
        input  in_ready, out_valid, out_r, div_ce, div_x, div_y
    );

    // Adapter side.
    modport slave (
        input  in_valid, in_x, in_y, out_ready, div_r,
        output in_ready, out_valid, out_r, div_ce, div_x, div_y
    );

endinterface

// File: rtl/fpdiv_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers for any DEPTH >= 1.
// Ports: clk, rst (async high), push/push_data, pop/pop_data, full, empty, count.
module fpdiv_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Explicit wrap so non-power-of-two depths never address past the end.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fpdiv_sp_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency, ce-gated FloPoCo SP divider.
// Ports: clk, rst (async high), io (slave): in_*, out_*, div_* stream/divider signals.
module fpdiv_sp_stream_adapter
    import fpdiv_pkg::*;
#(
    parameter int NUM_STAGES = 8,
    parameter int DEPTH      = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    fpdiv_sp_stream_adapter_if.slave   io
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_STAGES-1:0] vld_sr_q, vld_sr_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic                  accept, pop, arrival;
    logic                  fifo_full, fifo_empty;
    logic [CW-1:0]         fifo_count;

    // Divider free-runs; operands are forwarded unconditionally and
    // only the valid shift register decides what is a real result.
    assign io.div_ce = !rst;
    assign io.div_x  = io.in_x;
    assign io.div_y  = io.in_y;

    // Ready depends only on registered credits, never on out_ready.
    assign io.in_ready  = !rst && (credits_q != '0);
    assign io.out_valid = !fifo_empty;

    assign accept  = io.in_valid && io.in_ready;
    assign pop     = io.out_valid && io.out_ready;
    assign arrival = vld_sr_q[NUM_STAGES-1];

    always_comb begin
        vld_sr_d  = (vld_sr_q << 1) | NUM_STAGES'(accept);
        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - CW'(1);
            2'b01:   credits_d = credits_q + CW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q  <= '0;
            credits_q <= CW'(DEPTH);
        end else begin
            vld_sr_q  <= vld_sr_d;
            credits_q <= credits_d;
        end
    end

    fpdiv_sync_fifo #(
        .WIDTH (FP_SP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (arrival),
        .push_data (io.div_r),
        .pop       (pop),
        .pop_data  (io.out_r),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Every credit is either free, in the divider, or parked in the FIFO.
    a_credit_inv : assert property (
        @(posedge clk) disable iff (rst)
        int'(credits_q) + $countones(vld_sr_q) + int'(fifo_count) == DEPTH
    );

    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(arrival && fifo_full && !pop)
    );

endmodule
